// File: rtl/vga_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_monitor
// Purpose  : VGA sink that measures line/frame geometry, locks on a correct
//            frame, flags timing/blanking faults and checksums each frame.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        clear,
  output logic        locked,
  output logic        frame_done,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err,
  output logic [11:0] h_meas,
  output logic [10:0] v_meas,
  output logic [15:0] frame_sum,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam logic [11:0] c_h_total = 12'(H_TOTAL);
  localparam logic [11:0] c_h_tmo   = 12'(2 * H_TOTAL);
  localparam logic [11:0] c_h_sync  = 12'(H_SYNC);
  localparam logic [10:0] c_v_total = 11'(V_TOTAL);
  localparam logic [18:0] c_act_px  = 19'(H_ACTIVE * V_ACTIVE);

  state_t      r_state;
  logic        r_hs_prev, r_vs_prev, r_skip, r_frame_herr, r_frame_done;
  logic [11:0] r_hcnt, r_hwid, r_h_meas;
  logic [10:0] r_vcnt, r_v_meas;
  logic [18:0] r_act_cnt;
  logic [15:0] r_sum, r_frame_sum, r_frame_count;
  logic        r_h_err, r_v_err, r_blank_err;

  logic        w_hs_act, w_vs_act, w_hs_start, w_hs_end, w_vs_start, w_checking;
  logic [11:0] w_h_len;
  logic [10:0] w_v_len;
  logic [15:0] w_pix_sum;
  logic        w_timeout, w_len_bad, w_wid_bad, w_h_evt, w_frame_ok;
  logic        w_blank_bad, w_count_inc, w_v_set;

  assign w_hs_act   = vga_hs ~^ SYNC_POL;
  assign w_vs_act   = vga_vs ~^ SYNC_POL;
  assign w_hs_start = w_hs_act & ~r_hs_prev;
  assign w_hs_end   = ~w_hs_act & r_hs_prev;
  assign w_vs_start = w_vs_act & ~r_vs_prev;
  assign w_checking = (r_state != S_SEARCH);

  assign w_h_len    = r_hcnt + 12'd1;
  assign w_v_len    = r_vcnt + {10'd0, w_hs_start};
  assign w_pix_sum  = 16'(vga_r) + 16'(vga_g) + 16'(vga_b);

  // Fires once as hcnt reaches the limit; a saturated hcnt no longer matches.
  assign w_timeout  = ~w_hs_start & (w_h_len == c_h_tmo);
  assign w_len_bad  = w_hs_start & w_checking & ~r_skip & (w_h_len != c_h_total);
  assign w_wid_bad  = w_hs_end & w_checking & (r_hwid != c_h_sync);
  assign w_h_evt    = w_len_bad | w_wid_bad | w_timeout;
  assign w_frame_ok = (w_v_len == c_v_total) & (r_act_cnt == c_act_px);

  assign w_blank_bad = ~vga_blank_n & ({vga_r, vga_g, vga_b} != 24'd0);
  assign w_count_inc = pix_ce & w_vs_start & (r_state == S_LOCKED) & ~w_timeout;
  assign w_v_set     = w_count_inc & ~w_frame_ok;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_SEARCH;
      r_hs_prev    <= 1'b0;
      r_vs_prev    <= 1'b0;
      r_skip       <= 1'b0;
      r_frame_herr <= 1'b0;
      r_frame_done <= 1'b0;
      r_hcnt       <= 12'd0;
      r_hwid       <= 12'd0;
      r_h_meas     <= 12'd0;
      r_vcnt       <= 11'd0;
      r_v_meas     <= 11'd0;
      r_act_cnt    <= 19'd0;
      r_sum        <= 16'd0;
      r_frame_sum  <= 16'd0;
    end else if (pix_ce) begin
      r_hs_prev <= w_hs_act;
      r_vs_prev <= w_vs_act;

      if (w_hs_start) begin
        r_hcnt   <= 12'd0;
        r_h_meas <= w_h_len;
      end else if (r_hcnt != c_h_tmo) begin
        r_hcnt <= w_h_len;
      end

      if (w_hs_start)
        r_hwid <= 12'd1;
      else if (w_hs_act && r_hwid != 12'hFFF)
        r_hwid <= r_hwid + 12'd1;

      if (w_vs_start)
        r_vcnt <= 11'd0;
      else if (w_hs_start)
        r_vcnt <= r_vcnt + 11'd1;

      // The vs_start sample itself belongs to the new frame.
      if (w_vs_start) begin
        r_v_meas  <= w_v_len;
        r_act_cnt <= {18'd0, vga_blank_n};
        r_sum     <= vga_blank_n ? w_pix_sum : 16'd0;
        if (w_checking)
          r_frame_sum <= r_sum;
      end else if (vga_blank_n) begin
        r_act_cnt <= r_act_cnt + 19'd1;
        r_sum     <= r_sum + w_pix_sum;
      end

      if (r_state == S_SEARCH)
        r_skip <= 1'b1;
      else if (w_hs_start)
        r_skip <= 1'b0;

      if (w_vs_start)
        r_frame_herr <= 1'b0;
      else if (w_h_evt)
        r_frame_herr <= 1'b1;

      r_frame_done <= 1'b0;
      if (w_timeout) begin
        r_state <= S_SEARCH;
      end else begin
        case (r_state)
          S_SEARCH: begin
            if (w_vs_start)
              r_state <= S_MEASURE;
          end
          S_MEASURE: begin
            if (w_vs_start) begin
              r_frame_done <= 1'b1;
              if (w_frame_ok && !r_frame_herr && !w_h_evt)
                r_state <= S_LOCKED;
            end
          end
          S_LOCKED: begin
            if (w_vs_start)
              r_frame_done <= 1'b1;
            if (w_h_evt || (w_vs_start && !w_frame_ok))
              r_state <= S_SEARCH;
          end
          default: r_state <= S_SEARCH;
        endcase
      end
    end
  end

  // Sticky flags and frame counter see clear on every clock; a coincident event wins.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_h_err       <= 1'b0;
      r_v_err       <= 1'b0;
      r_blank_err   <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_h_err     <= (r_h_err & ~clear) | (pix_ce & w_h_evt);
      r_v_err     <= (r_v_err & ~clear) | w_v_set;
      r_blank_err <= (r_blank_err & ~clear) | (pix_ce & w_blank_bad);
      if (w_count_inc)
        r_frame_count <= clear ? 16'd1 : r_frame_count + 16'd1;
      else if (clear)
        r_frame_count <= 16'd0;
    end
  end

  assign locked      = (r_state == S_LOCKED);
  assign frame_done  = r_frame_done & pix_ce;
  assign h_err       = r_h_err;
  assign v_err       = r_v_err;
  assign blank_err   = r_blank_err;
  assign h_meas      = r_h_meas;
  assign v_meas      = r_v_meas;
  assign frame_sum   = r_frame_sum;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_monitor
// Purpose  : Directed bench for vga_timing_monitor on a 10x6 test raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_monitor;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b0;
  logic        vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0;
  logic [7:0]  vga_r = 8'd0, vga_g = 8'd0, vga_b = 8'd0;
  logic        clear = 1'b0;
  logic        locked, frame_done, h_err, v_err, blank_err;
  logic [11:0] h_meas;
  logic [10:0] v_meas;
  logic [15:0] frame_sum, frame_count;

  int n_vec = 0, n_err = 0;
  int pix_n = 0, vs_cnt = 0;
  int fd_cnt = 0, fd_at = -1;
  logic [15:0] fd_sum = 16'd0;
  logic [11:0] fd_hmeas = 12'd0, herr_hmeas = 12'd0;
  logic [10:0] fd_vmeas = 11'd0;
  int lock_at = -1, lock_fall_at = -1, herr_at = -1, verr_at = -1;
  logic lock_prev = 1'b0, herr_prev = 1'b0, verr_prev = 1'b0;

  vga_timing_monitor #(
    .H_TOTAL(10), .H_ACTIVE(8), .H_SYNC(1),
    .V_TOTAL(6), .V_ACTIVE(4), .SYNC_POL(1'b0)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pix_ce(pix_ce),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .clear(clear),
    .locked(locked), .frame_done(frame_done), .h_err(h_err),
    .v_err(v_err), .blank_err(blank_err), .h_meas(h_meas),
    .v_meas(v_meas), .frame_sum(frame_sum), .frame_count(frame_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel: a pix_ce cycle followed by an idle cycle; events are logged by pixel index.
  task automatic pix(input logic hs, input logic vs, input logic bn,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic cl);
    int idx;
    idx = pix_n;
    pix_n++;
    @(negedge CLOCK_50);
    vga_hs = hs; vga_vs = vs; vga_blank_n = bn;
    vga_r = r; vga_g = g; vga_b = b;
    clear = cl; pix_ce = 1'b1;
    #2;
    if (frame_done) begin
      fd_cnt++;
      fd_at    = idx;
      fd_sum   = frame_sum;
      fd_hmeas = h_meas;
      fd_vmeas = v_meas;
    end
    @(negedge CLOCK_50);
    pix_ce = 1'b0; clear = 1'b0;
    #2;
    if (locked && !lock_prev) lock_at = vs_cnt;
    if (!locked && lock_prev) lock_fall_at = idx;
    if (h_err && !herr_prev) begin
      herr_at    = idx;
      herr_hmeas = h_meas;
    end
    if (v_err && !verr_prev) verr_at = idx;
    lock_prev = locked; herr_prev = h_err; verr_prev = v_err;
  endtask

  // Line: HS on pixel 0, active pixels 1..8; frame: VS on line 0, active lines 1..4.
  task automatic frame(input int nl = 6, input int long_l = -1, input int viol_l = -1,
                       input int clr_l = -1, input int clr_p = -1);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == long_l) ? 11 : 10;
      for (int p = 0; p < len; p++) begin
        logic act, viol, cl;
        act  = (l >= 1 && l <= 4 && p >= 1 && p <= 8);
        viol = (l == viol_l && p == 9);
        cl   = (l == clr_l && p == clr_p);
        if (l == 0 && p == 0) vs_cnt++;
        pix(p != 0, l != 0, act, act ? 8'd1 : (viol ? 8'd5 : 8'd0),
            act ? 8'd1 : 8'd0, act ? 8'd1 : 8'd0, cl);
      end
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge CLOCK_50);
    #2;
    clear = 1'b0;
  endtask

  initial begin
    int base, vb, fd_save;

    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    #2;
    chk("rst_flags", {locked, frame_done, h_err, v_err, blank_err}, 0);
    chk("rst_meas", {h_meas, v_meas}, 0);
    chk("rst_sum", frame_sum, 0);
    chk("rst_count", frame_count, 0);

    // Clean frames
    frame(); frame(); frame();
    chk("s1_lock_vs", lock_at, 2);
    chk("s1_locked", locked, 1);
    chk("s1_fd_cnt", fd_cnt, 2);
    chk("s1_fd_sum", fd_sum, 96);
    chk("s1_fd_hmeas", fd_hmeas, 10);
    chk("s1_fd_vmeas", fd_vmeas, 6);
    chk("s1_count", frame_count, 1);
    chk("s1_errs", {h_err, v_err, blank_err}, 0);

    // 11-pixel line while locked
    base = pix_n;
    frame(6, 2);
    chk("s2_herr_at", herr_at, base + 31);
    chk("s2_herr_hmeas", herr_hmeas, 11);
    chk("s2_lockfall_at", lock_fall_at, base + 31);
    frame(); frame();
    chk("s2_relock_vs", lock_at, 6);
    chk("s2_herr_sticky", h_err, 1);
    pulse_clear();
    chk("s2_herr_clr", h_err, 0);
    chk("s2_count_clr", frame_count, 0);

    // 7-line frame while locked
    frame(7);
    base = pix_n;
    frame();
    chk("s3_verr_at", verr_at, base);
    chk("s3_fd_at", fd_at, base + 1);
    chk("s3_fd_vmeas", fd_vmeas, 7);
    chk("s3_locked", locked, 0);
    chk("s3_herr", h_err, 0);
    chk("s3_count", frame_count, 2);
    fd_save = fd_cnt;
    frame();
    chk("s3_no_fd_search", fd_cnt, fd_save);

    // Blanking violations
    frame();
    frame(6, -1, 2);
    chk("s4_blank_err", blank_err, 1);
    chk("s4_locked", locked, 1);
    pulse_clear();
    chk("s4_blank_clr", blank_err, 0);
    frame(6, -1, 2, 2, 9);
    chk("s4_blank_vs_clr", blank_err, 1);
    chk("s4_locked2", locked, 1);

    // HS stops while locked, then reset mid-frame
    base = pix_n;
    repeat (25) pix(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    chk("s5_herr_at", herr_at, base + 10);
    chk("s5_lockfall_at", lock_fall_at, base + 10);
    chk("s5_herr", h_err, 1);
    reset = 1'b1;
    #1;
    chk("s5_rst_flags", {locked, frame_done, h_err, v_err, blank_err}, 0);
    chk("s5_rst_meas", {h_meas, v_meas}, 0);
    chk("s5_rst_sum_cnt", {frame_sum, frame_count}, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    #2;

    // Relock after reset, frame_count wrap and clear-vs-increment
    vb = vs_cnt;
    frame();
    chk("s6_not_locked", locked, 0);
    frame();
    chk("s6_relock", locked, 1);
    chk("s6_relock_vs", lock_at, vb + 2);
    force dut.r_frame_count = 16'hFFFF;
    @(negedge CLOCK_50);
    release dut.r_frame_count;
    #2;
    frame();
    chk("s6_wrap", frame_count, 0);
    frame();
    chk("s6_inc", frame_count, 1);
    frame(6, -1, -1, 0, 0);
    chk("s6_clr_inc", frame_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Synthesizable receiver-side checker for the VGA output of the Proyecto2 top level.
- Samples VGA_HS, VGA_VS, VGA_BLANK_N and RGB on each pixel-clock enable, and measures line and frame geometry.
- Checks the measurements against the configured timing, locks once a full frame matches, and reports a per-frame pixel checksum.
- Used on-board (errors to LEDR) and in simulation as a self-checking sink for the display path.

Parameters:
H_TOTAL, 800, pixel clocks per line
H_ACTIVE, 640, active (blank_n=1) pixels per line
H_SYNC, 96, HS assertion width in pixel clocks
V_TOTAL, 525, lines per frame
V_ACTIVE, 480, active lines per frame
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
pix_ce  in  1  pixel enable, one CLOCK_50 cycle per VGA_CLK period
vga_hs  in  1  horizontal sync
vga_vs  in  1  vertical sync
vga_blank_n  in  1  1 = active video
vga_r  in  8  red
vga_g  in  8  green
vga_b  in  8  blue
clear  in  1  synchronous clear of sticky flags and frame_count
locked  out  1  timing locked
frame_done  out  1  one-cycle pulse at each frame boundary
h_err  out  1  sticky: line length or HS width mismatch, or HS timeout
v_err  out  1  sticky: frame line count or active pixel count mismatch
blank_err  out  1  sticky: nonzero RGB while blank_n=0
h_meas  out  12  last measured line length
v_meas  out  11  last measured line count
frame_sum  out  16  checksum of last completed frame
frame_count  out  16  frames completed while locked

Behaviour:
Reset and sampling
- On reset: all outputs 0, all counters 0, state SEARCH.
- All logic updates only on CLOCK_50 cycles with pix_ce=1, except clear.
- hs_act = vga_hs XNOR SYNC_POL; vs_act likewise.
- hs_start / vs_start = rising edge of hs_act / vs_act relative to the previous pix_ce sample.

Horizontal
- hcnt increments every pix_ce.
- On hs_start: h_meas <= hcnt+1; hcnt <= 0.
- HS width counter runs while hs_act. On deassertion, width != H_SYNC sets h_err (states MEASURE/LOCKED only).
- In MEASURE/LOCKED, hs_start with hcnt+1 != H_TOTAL sets h_err. The first hs_start after SEARCH is not checked.
- Timeout: hcnt reaching 2*H_TOTAL with no hs_start sets h_err, forces state SEARCH, and saturates hcnt.

Vertical
- vcnt increments on hs_start.
- On vs_start: v_meas <= vcnt + (hs_start ? 1 : 0); vcnt <= 0.
- With VS coincident with HS, a correct frame measures exactly V_TOTAL.

Per-frame accumulators (cleared at vs_start)
- act_cnt (19 bits) counts pix_ce samples with blank_n=1.
- sum (16 bits) accumulates vga_r+vga_g+vga_b on active samples, modulo 2^16.
- Any sample with blank_n=0 and {r,g,b} != 0 sets blank_err, in any state.

State machine
- SEARCH: on vs_start -> MEASURE, accumulators cleared. No checks, no frame_done.
- MEASURE: on vs_start, frame_done pulses.
  - If v_meas==V_TOTAL, act_cnt==H_ACTIVE*V_ACTIVE and no h_err event during the frame -> LOCKED.
  - Otherwise stay in MEASURE. No v_err is raised here.
- LOCKED: on vs_start, frame_done pulses and frame_count increments (wraps at 0xFFFF -> 0).
  - If v_meas or act_cnt mismatch: set v_err, -> SEARCH.
  - Any h_err event -> SEARCH at that cycle.
- locked = (state==LOCKED), registered.

frame_done timing
- frame_sum, h_meas and v_meas are valid in the same cycle frame_done is high; they hold until the next frame.
- frame_done is forced 0 when pix_ce=0.

Clear and reset precedence
- clear zeroes h_err, v_err, blank_err and frame_count; state is unaffected.
- clear coincident with an error event: the error flag ends up set.
- clear coincident with a frame_count increment: frame_count ends 1.
- reset mid-frame returns to SEARCH immediately. Relock needs two vs_starts.

Test Plan:
Common setup for all scenarios: small timing, H_TOTAL=10, H_ACTIVE=8, H_SYNC=1, V_TOTAL=6, V_ACTIVE=4, SYNC_POL=0, pix_ce every other CLOCK_50 cycle. Generator drives RGB = 1,1,1 on active pixels.
1. Three clean frames -> locked rises at 2nd vs_start; frame_sum=96 (32 px x 3); h_meas=10, v_meas=6; frame_count=1 after 3rd vs_start; no error flags.
2. Locked, then one line of 11 pixels -> h_err=1 at that hs_start, locked=0 next cycle; relocks 2 frames after clean timing resumes; h_err stays 1 until clear.
3. Locked, then one frame of 7 lines -> v_err=1 and frame_done at that vs_start, state SEARCH; h_err remains 0.
4. Drive r=5 during blanking for one sample -> blank_err=1 and locked unaffected; clear pulsed in the same cycle as a second violation -> blank_err stays 1.
5. Stop HS for 20+ pix_ce while locked -> h_err=1, locked=0; assert reset mid-frame -> all outputs 0 within the same cycle.
6. frame_count preset by running 65536 locked frames (or force) -> next frame wraps frame_count to 0; clear with a simultaneous increment -> frame_count=1.
